uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one multi-byte UART packet transmitter between `NUM_REQ` requesters, such as the CPU store path, the debug dump unit and the memory loader. It accepts one 42-bit packet at a time over a valid/ready handshake and drives the transmitter's `start`/`data_in` inputs. It waits for the transmitter's `done`, then returns a per-requester completion pulse. A watchdog flags a transmitter that never completes.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range is 2 to 8.
- `PKT_W`, default 42: packet width, formatted as `{target_mem[41], target_addr[40:32], data[31:0]}`.
- `TIMEOUT_CYCLES`, default 65535: maximum cycles to wait for `tx_done`. A value of 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset).
- `req_valid`, in, `NUM_REQ`: bit i set means requester i presents a packet.
- `req_data`, in, `NUM_REQ*PKT_W`: packet of requester i at bits `[i*PKT_W +: PKT_W]`.
- `req_ready`, out, `NUM_REQ`: one-hot or zero. Bit i set means requester i's packet is accepted this cycle.
- `req_done`, out, `NUM_REQ`: one-cycle pulse to the owning requester when its packet finishes or aborts.
- `req_err`, out, 1: qualifies `req_done`. 1 means the packet was aborted by timeout.
- `tx_start`, out, 1: one-cycle start pulse to the transmitter.
- `tx_data`, out, `PKT_W`: packet to the transmitter. Held stable from acceptance until the next acceptance.
- `tx_done`, in, 1: one-cycle completion pulse from the transmitter.
- `busy`, out, 1: high in every state except IDLE.
- `grant_id`, out, `$clog2(NUM_REQ)`: index of the current or most recent owner.
- `timeout_err`, out, 1: sticky watchdog flag. Cleared only by reset.

## Operation
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `tx_data` 0, `wd_cnt` 0. All outputs are 0.
- The state machine has four states: IDLE, START, WAIT, FINISH.
- IDLE:
  - The winner is the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready[winner]` is driven combinationally in the same cycle.
  - On that edge: latch `req_data[winner]` into `tx_data`, set `grant_id` to the winner, go to START.
  - With no valid request, remain in IDLE and drive `req_ready` to 0.
- START: `tx_start` is 1 for exactly one cycle. Clear `wd_cnt`. Go to WAIT.
- WAIT:
  - On `tx_done`, go to FINISH with the error bit at 0.
  - Otherwise increment `wd_cnt`.
  - If `TIMEOUT_CYCLES` is nonzero and `wd_cnt` reaches `TIMEOUT_CYCLES-1` without `tx_done`: set `timeout_err`, go to FINISH with the error bit at 1.
- FINISH:
  - Pulse `req_done[grant_id]`, and set `req_err` to the error bit.
  - Set `rr_ptr` to `grant_id+1`, wrapping `NUM_REQ-1` to 0.
  - Go to IDLE.
- `tx_done` is ignored outside WAIT. A stray pulse has no effect.
- Requesters must hold `req_valid` and `req_data` stable until `req_ready`. A request dropped before acceptance is never sent.
- A timeout does not reset the transmitter. A later `tx_start` may be ignored if the transmitter is still busy. `timeout_err` is a fatal diagnostic for software.
- Asynchronous reset mid-packet immediately returns all state and outputs to reset values. The in-flight packet is lost and no `req_done` is issued.

## Timing
- If a request is accepted at edge T (with `req_ready` high in cycle T), then `tx_start` is high in cycle T+1.
- `tx_data` is valid from cycle T+1 and unchanged through WAIT and FINISH.
- If `tx_done` is high in cycle D, then `req_done` is high in cycle D+1. The block is in IDLE in cycle D+2 and can accept the next packet.
- A packet costs the transmitter latency plus 3 arbiter cycles (IDLE, START, FINISH).
- Fairness: each requester with `req_valid` held high is granted within `NUM_REQ` packets.
- Timeout with the error path: `req_done` and `req_err` go high `TIMEOUT_CYCLES`+1 cycles after the `tx_start` cycle.

## Test plan
- Single request (`NUM_REQ`=4, `TIMEOUT_CYCLES`=20):
  - Stimulus: `req_valid`=0010 with `req_data[1]`=0x2_0A_DEADBEEF. The transmitter model returns `tx_done` 10 cycles after `tx_start`.
  - Required: `tx_start` 1 cycle after `req_ready`, `tx_data`=0x20ADEADBEEF, and `req_done`=0010 with `req_err`=0 one cycle after `tx_done`.
- Round robin: hold `req_valid`=1111 continuously from reset. Required grant order 0,1,2,3,0,1, each packet completing before the next `req_ready`.
- Pointer wrap and skip: after requester 3 is granted, `req_valid`=0101. Required: next grant 0, then 2, then 0.
- Timeout: the transmitter never asserts `tx_done`. Required:
  - `req_done[grant_id]` and `req_err` pulse 21 cycles after `tx_start`.
  - `timeout_err` stays 1.
  - The next request is still accepted.
- Stray `tx_done` pulses in IDLE and START: no state change and no `req_done`. Simultaneous `req_valid` 1100 when `rr_ptr`=3 grants 3.
- Reset mid-operation: assert `reset`=0 during WAIT. Required: all outputs 0 immediately, and the first grant after release goes to requester 0 (`rr_ptr`=0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one multi-byte UART packet transmitter
//   between NUM_REQ requesters. It accepts one packet at a time, starts the
//   transmitter, and waits for its completion. It then returns a completion
//   pulse to the owning requester. A watchdog aborts a packet whose
//   transmitter never reports done.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   req_valid    per-requester packet-present flags
//   req_data     packets, requester i at [i*PKT_W +: PKT_W]
//   req_ready    one-hot accept strobe (combinational, IDLE only)
//   req_done     one-cycle completion pulse to the owning requester
//   req_err      qualifies req_done: 1 = aborted by watchdog
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      packet to the transmitter, held until the next acceptance
//   tx_done      one-cycle completion pulse from the transmitter
//   busy         high whenever the sequencer is not idle
//   grant_id     index of the current or most recent owner
//   timeout_err  sticky watchdog flag, cleared only by reset
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PKT_W          = 42,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*PKT_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       req_err,
  output logic                       tx_start,
  output logic [PKT_W-1:0]           tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [WD_W-1:0]  wd_cnt;
  logic             err_bit;     // abort status of the packet in flight
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  int               idx;
  logic [PKT_W-1:0] sel_data;
  logic             wd_expire;

  // Round-robin search: the first valid requester at or above rr_ptr,
  // wrapping modulo NUM_REQ (which need not be a power of two).
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_data = req_data[i*PKT_W +: PKT_W];
    end
  end

  assign wd_expire = WD_EN && (wd_cnt == WD_LIMIT);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    req_done  = '0;
    req_err   = 1'b0;
    tx_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_START;
          // Gated by reset so every output reads 0 while reset is held,
          // even if a requester keeps req_valid high.
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = reset && (winner == ID_W'(i));
          end
        end
      end
      S_START: begin
        tx_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done || wd_expire) state_nxt = S_FINISH;
      end
      S_FINISH: begin
        req_err = err_bit;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_done[i] = (grant_id == ID_W'(i));
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      wd_cnt      <= '0;
      err_bit     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (found) begin
            tx_data  <= sel_data;
            grant_id <= winner;
          end
        end
        S_START: begin
          wd_cnt  <= '0;
          err_bit <= 1'b0;
        end
        S_WAIT: begin
          // tx_done wins over an expiring watchdog in the same cycle.
          if (!tx_done) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire) begin
              timeout_err <= 1'b1;
              err_bit     <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with NUM_REQ=4, TIMEOUT_CYCLES=20.
//   A small transmitter model answers tx_start with tx_done after tx_lat
//   cycles (tx_lat = 0 means it never answers). Inputs change and outputs
//   are sampled one time unit after the falling clock edge.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int PKT_W   = 42;
  localparam int TMO     = 20;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*PKT_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_done;
  logic                     req_err;
  logic                     tx_start;
  logic [PKT_W-1:0]         tx_data;
  logic                     tx_done;
  logic                     busy;
  logic [1:0]               grant_id;
  logic                     timeout_err;

  logic model_done;
  logic stray;
  int   tx_lat;
  int   cnt;
  int   passed;
  int   total;

  assign tx_done = model_done | stray;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PKT_W(PKT_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .req_done(req_done),
    .req_err(req_err),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .busy(busy),
    .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: tx_start seen in cycle S gives tx_done in S+tx_lat.
  initial begin
    model_done = 1'b0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (!reset) cnt = 0;
      else if (tx_start && tx_lat > 0) cnt = tx_lat;
      else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) model_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got stuck, required completion");
    $fatal(1, "bench time limit");
  end

  function automatic logic [PKT_W-1:0] pkt(input int i);
    pkt = {1'b0, 9'(i + 16), 32'hA5A5_0000 + 32'(i)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max, output int k);
    k = -1;
    #1;
    for (int i = 0; i <= max; i++) begin
      if (req_ready !== 4'b0000) begin
        k = i;
        break;
      end
      step();
    end
  endtask

  // Called in the tx_start cycle; k = cycles until req_done, -1 if never.
  task automatic wait_done(input int max, output int k);
    k = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (req_done !== 4'b0000) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    req_valid = '0;
    stray     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_packet(input int id, input logic [PKT_W-1:0] exp_data, input int lat);
    int k;
    logic [3:0] oh;
    oh     = 4'b0001 << id;
    tx_lat = lat;
    wait_ready(50, k);
    total++;
    if (k < 0 || req_ready !== oh) $display("FAIL grant_%0d: req_ready=%b required %b", id, req_ready, oh);
    else passed++;
    step();
    total++;
    if (tx_start !== 1'b1 || tx_data !== exp_data || grant_id !== 2'(id))
      $display("FAIL start_%0d: tx_start=%b tx_data=%h grant_id=%0d required 1 %h %0d",
               id, tx_start, tx_data, grant_id, exp_data, id);
    else passed++;
    wait_done(lat + 10, k);
    total++;
    if (k != lat + 1) $display("FAIL done_latency_%0d: got %0d cycles required %0d", id, k, lat + 1);
    else passed++;
    total++;
    if (req_done !== oh || req_err !== 1'b0)
      $display("FAIL done_%0d: req_done=%b req_err=%b required %b 0", id, req_done, req_err, oh);
    else passed++;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    stray     = 1'b0;
    tx_lat    = 0;
    #1;
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== 4'b0 || req_done !== 4'b0 || req_err !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b tx_start=%b req_ready=%b req_done=%b req_err=%b required all 0",
               busy, tx_start, req_ready, req_done, req_err);
    else passed++;
    total++;
    if (tx_data !== '0 || grant_id !== 2'd0 || timeout_err !== 1'b0)
      $display("FAIL reset_regs: tx_data=%h grant_id=%0d timeout_err=%b required 0 0 0",
               tx_data, grant_id, timeout_err);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_single();
    req_data[1*PKT_W +: PKT_W] = 42'h20ADEADBEEF;
    req_valid = 4'b0010;
    run_packet(1, 42'h20ADEADBEEF, 10);
    req_valid = 4'b0000;
    step();
    total++;
    if (busy !== 1'b0 || req_done !== 4'b0 || tx_data !== 42'h20ADEADBEEF)
      $display("FAIL single_idle: busy=%b req_done=%b tx_data=%h required 0 0000 20adeadbeef",
               busy, req_done, tx_data);
    else passed++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*PKT_W +: PKT_W] = pkt(i);
    req_valid = 4'b1111;
    run_packet(0, pkt(0), 3);
    run_packet(1, pkt(1), 3);
    run_packet(2, pkt(2), 3);
    run_packet(3, pkt(3), 3);
    run_packet(0, pkt(0), 3);
    run_packet(1, pkt(1), 3);
  endtask

  task automatic test_wrap_skip();
    run_packet(2, pkt(2), 2);
    run_packet(3, pkt(3), 2);
    req_valid = 4'b0101;
    run_packet(0, pkt(0), 2);
    run_packet(2, pkt(2), 2);
    run_packet(0, pkt(0), 2);
    req_valid = 4'b0000;
  endtask

  task automatic test_timeout();
    int k;
    tx_lat    = 0;
    req_valid = 4'b0100;
    wait_ready(50, k);
    total++;
    if (k < 0 || req_ready !== 4'b0100) $display("FAIL tmo_grant: req_ready=%b required 0100", req_ready);
    else passed++;
    step();
    total++;
    if (tx_start !== 1'b1) $display("FAIL tmo_start: tx_start=%b required 1", tx_start);
    else passed++;
    wait_done(60, k);
    total++;
    if (k != TMO + 1) $display("FAIL tmo_latency: got %0d cycles required %0d", k, TMO + 1);
    else passed++;
    total++;
    if (req_done !== 4'b0100 || req_err !== 1'b1 || timeout_err !== 1'b1)
      $display("FAIL tmo_done: req_done=%b req_err=%b timeout_err=%b required 0100 1 1",
               req_done, req_err, timeout_err);
    else passed++;
    req_valid = 4'b0000;
    repeat (3) step();
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL tmo_sticky: timeout_err=%b busy=%b required 1 0", timeout_err, busy);
    else passed++;
    req_valid = 4'b1000;
    run_packet(3, pkt(3), 5);
    req_valid = 4'b0000;
    total++;
    if (timeout_err !== 1'b1) $display("FAIL tmo_sticky2: timeout_err=%b required 1", timeout_err);
    else passed++;
  endtask

  task automatic test_stray();
    int k;
    req_valid = 4'b0100;
    run_packet(2, pkt(2), 3);
    req_valid = 4'b0000;
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    total++;
    if (busy !== 1'b0 || req_done !== 4'b0 || tx_start !== 1'b0)
      $display("FAIL stray_idle: busy=%b req_done=%b tx_start=%b required 0 0000 0", busy, req_done, tx_start);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0 || req_done !== 4'b0)
      $display("FAIL stray_idle2: busy=%b req_done=%b required 0 0000", busy, req_done);
    else passed++;
    tx_lat    = 4;
    req_valid = 4'b1100;
    wait_ready(50, k);
    total++;
    if (k < 0 || req_ready !== 4'b1000) $display("FAIL stray_grant: req_ready=%b required 1000", req_ready);
    else passed++;
    step();
    stray = 1'b1;
    total++;
    if (tx_start !== 1'b1 || grant_id !== 2'd3)
      $display("FAIL stray_start: tx_start=%b grant_id=%0d required 1 3", tx_start, grant_id);
    else passed++;
    step();
    stray = 1'b0;
    total++;
    if (busy !== 1'b1 || req_done !== 4'b0)
      $display("FAIL stray_start_ignored: busy=%b req_done=%b required 1 0000", busy, req_done);
    else passed++;
    wait_done(20, k);
    total++;
    if (k != 4 || req_done !== 4'b1000 || req_err !== 1'b0)
      $display("FAIL stray_done: cycles=%0d req_done=%b req_err=%b required 4 1000 0", k, req_done, req_err);
    else passed++;
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int k;
    req_valid = 4'b0010;
    run_packet(1, pkt(1), 3);
    tx_lat    = 0;
    req_valid = 4'b0100;
    wait_ready(50, k);
    total++;
    if (k < 0 || req_ready !== 4'b0100) $display("FAIL rmid_grant: req_ready=%b required 0100", req_ready);
    else passed++;
    repeat (3) step();
    total++;
    if (busy !== 1'b1) $display("FAIL rmid_wait: busy=%b required 1", busy);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || tx_data !== '0 || grant_id !== 2'd0 || req_ready !== 4'b0 ||
        req_done !== 4'b0 || tx_start !== 1'b0 || req_err !== 1'b0)
      $display("FAIL rmid_outputs: busy=%b tx_data=%h grant_id=%0d req_ready=%b req_done=%b tx_start=%b req_err=%b required all 0",
               busy, tx_data, grant_id, req_ready, req_done, tx_start, req_err);
    else passed++;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    run_packet(0, pkt(0), 3);
    req_valid = 4'b0000;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_timeout();
    test_stray();
    test_reset_mid();
    repeat (2) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
